// File: rtl/hilo_mult_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: the ALUCtl operation codes,
// the FSM state type, and helpers that classify operation codes.
package hilo_mult_unit_pkg;

   localparam logic [4:0] ALU_MULT  = 5'b00101;
   localparam logic [4:0] ALU_MULTU = 5'b01100;
   localparam logic [4:0] ALU_MADD  = 5'b11010;
   localparam logic [4:0] ALU_MSUB  = 5'b01101;
   localparam logic [4:0] ALU_MUL   = 5'b11000;
   localparam logic [4:0] ALU_MTHI  = 5'b10001;
   localparam logic [4:0] ALU_MTLO  = 5'b10011;
   localparam logic [4:0] ALU_MFHI  = 5'b10000;
   localparam logic [4:0] ALU_MFLO  = 5'b10010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_COMMIT
   } state_t;

   function automatic logic is_mult_op(input logic [4:0] code);
      return code inside {ALU_MULT, ALU_MULTU, ALU_MADD, ALU_MSUB, ALU_MUL};
   endfunction

   function automatic logic is_signed_op(input logic [4:0] code);
      return code inside {ALU_MULT, ALU_MADD, ALU_MSUB, ALU_MUL};
   endfunction

endpackage

// File: rtl/hilo_mult_unit_shift_add_mul_core.sv
// Unsigned iterative shift-add multiplier: Load captures the operands, each Step
// retires BITS_PER_CYCLE multiplier bits into the running Product.
module hilo_mult_unit_shift_add_mul_core #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Load,
   input  logic [WIDTH-1:0]     Ma,
   input  logic [WIDTH-1:0]     Mb,
   input  logic                 Step,
   output logic [2*WIDTH-1:0]   Product
);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] partial;

   // NOTE: partial gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      partial = Product;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (mplier[i]) partial = partial + (mcand << i);
      end
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         mcand   <= '0;
         mplier  <= '0;
         Product <= '0;
      end else if (Load) begin
         mcand   <= {{WIDTH{1'b0}}, Ma};
         mplier  <= Mb;
         Product <= '0;
      end else if (Step) begin
         Product <= partial;
         mcand   <= mcand << BITS_PER_CYCLE;
         mplier  <= mplier >> BITS_PER_CYCLE;
      end
   end

endmodule

// File: rtl/hilo_mult_unit.sv
// EX-stage HI/LO unit: owns HI/LO, executes move ops in one cycle and multiplies
// through an iterative core, stalling upstream with Busy until the commit edge.
module hilo_mult_unit
   import hilo_mult_unit_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [4:0]         ALUCtl,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               Busy,
   output logic               Done,
   output logic [WIDTH-1:0]   Result,
   output logic [WIDTH-1:0]   Hi,
   output logic [WIDTH-1:0]   Lo
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t             state;
   logic [CW-1:0]      count;
   logic [4:0]         op;
   logic               neg;
   logic               sgn_op;
   logic               load;
   logic               step;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] signed_p;
   logic [2*WIDTH-1:0] hilo_next;

   // Magnitudes of the most negative value still fit the unsigned core.
   always_comb begin
      sgn_op    = is_signed_op(ALUCtl);
      mag_a     = (sgn_op && A[WIDTH-1]) ? -A : A;
      mag_b     = (sgn_op && B[WIDTH-1]) ? -B : B;
      load      = (state == ST_IDLE) && Start && is_mult_op(ALUCtl);
      step      = (state == ST_RUN);
      signed_p  = neg ? -product : product;
      hilo_next = signed_p;
      if (op == ALU_MADD)      hilo_next = {Hi, Lo} + signed_p;
      else if (op == ALU_MSUB) hilo_next = {Hi, Lo} - signed_p;
   end

   hilo_mult_unit_shift_add_mul_core #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_core (
      .Clk     (Clk),
      .Reset   (Reset),
      .Load    (load),
      .Ma      (mag_a),
      .Mb      (mag_b),
      .Step    (step),
      .Product (product)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= ST_IDLE;
         count  <= '0;
         op     <= '0;
         neg    <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
         Result <= '0;
         Hi     <= '0;
         Lo     <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  if (is_mult_op(ALUCtl)) begin
                     op    <= ALUCtl;
                     neg   <= sgn_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                     count <= '0;
                     Busy  <= 1'b1;
                     state <= ST_RUN;
                  end else begin
                     // Moves read HI/LO before this edge's update.
                     case (ALUCtl)
                        ALU_MTHI: begin Hi <= A;      Result <= '0; Done <= 1'b1; end
                        ALU_MTLO: begin Lo <= A;      Result <= '0; Done <= 1'b1; end
                        ALU_MFHI: begin Result <= Hi; Done <= 1'b1; end
                        ALU_MFLO: begin Result <= Lo; Done <= 1'b1; end
                        default: ;
                     endcase
                  end
               end
            end
            ST_RUN: begin
               count <= count + 1'b1;
               if (count == CW'(N - 1)) state <= ST_COMMIT;
            end
            ST_COMMIT: begin
               if (op == ALU_MUL) begin
                  Result <= signed_p[WIDTH-1:0];
               end else begin
                  Result   <= '0;
                  {Hi, Lo} <= hilo_next;
               end
               Done  <= 1'b1;
               Busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit: directed cases plus randomized ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_hilo_mult_unit;
   import hilo_mult_unit_pkg::*;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          Clk;
   logic          Reset;
   logic          Start;
   logic [4:0]    ALUCtl;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Busy;
   logic          Done;
   logic [W-1:0]  Result;
   logic [W-1:0]  Hi;
   logic [W-1:0]  Lo;

   int n_compared;
   int n_mismatched;

   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;
   logic [W-1:0] m_res;

   hilo_mult_unit #(
      .WIDTH          (W),
      .BITS_PER_CYCLE (1)
   ) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Start  (Start),
      .ALUCtl (ALUCtl),
      .A      (A),
      .B      (B),
      .Busy   (Busy),
      .Done   (Done),
      .Result (Result),
      .Hi     (Hi),
      .Lo     (Lo)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: 64-bit integer arithmetic on whole HI:LO, no iteration.
   task automatic model_op(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] p;
      logic [63:0] acc;
      if (code == ALU_MULTU) p = {32'h0, a} * {32'h0, b};
      else                   p = longint'($signed(a)) * longint'($signed(b));
      acc = {m_hi, m_lo};
      case (code)
         ALU_MULT, ALU_MULTU: begin {m_hi, m_lo} = p;       m_res = '0; end
         ALU_MADD:            begin {m_hi, m_lo} = acc + p; m_res = '0; end
         ALU_MSUB:            begin {m_hi, m_lo} = acc - p; m_res = '0; end
         ALU_MUL:             m_res = p[31:0];
         ALU_MTHI:            begin m_hi = a; m_res = '0; end
         ALU_MTLO:            begin m_lo = a; m_res = '0; end
         ALU_MFHI:            m_res = m_hi;
         ALU_MFLO:            m_res = m_lo;
         default: ;
      endcase
   endtask

   // Called and returns at a negedge; the next call may start back-to-back.
   task automatic do_op(input string tag, input logic [4:0] code,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      int cycles;
      int busy_cnt;
      bit multi;
      bit single;
      multi  = code inside {ALU_MULT, ALU_MULTU, ALU_MADD, ALU_MSUB, ALU_MUL};
      single = code inside {ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO};
      ALUCtl = code;
      A      = a;
      B      = b;
      Start  = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      model_op(code, a, b);
      if (multi) begin
         cycles   = 1;
         busy_cnt = 0;
         while (!Done && cycles < 100) begin
            if (Busy) busy_cnt++;
            @(negedge Clk);
            cycles++;
         end
         check({tag, "_latency"}, 64'(cycles - 1), 64'(LAT));
         check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
      end else if (single) begin
         check({tag, "_done"}, 64'(Done), 64'd1);
      end else begin
         check({tag, "_no_done"}, 64'(Done), 64'd0);
      end
      check({tag, "_busy_low"}, 64'(Busy), 64'd0);
      check({tag, "_hi"}, 64'(Hi), 64'(m_hi));
      check({tag, "_lo"}, 64'(Lo), 64'(m_lo));
      check({tag, "_result"}, 64'(Result), 64'(m_res));
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [4:0] codes [11];
      int done_cnt;
      n_compared   = 0;
      n_mismatched = 0;
      m_hi  = '0;
      m_lo  = '0;
      m_res = '0;
      Reset  = 1'b1;
      Start  = 1'b0;
      ALUCtl = '0;
      A      = '0;
      B      = '0;

      repeat (2) @(negedge Clk);
      check("reset_hi", 64'(Hi), 64'd0);
      check("reset_lo", 64'(Lo), 64'd0);
      check("reset_result", 64'(Result), 64'd0);
      check("reset_busy", 64'(Busy), 64'd0);
      check("reset_done", 64'(Done), 64'd0);
      Reset = 1'b0;
      @(negedge Clk);

      do_op("mult_neg", ALU_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
      check("mult_neg_hi_const", 64'(Hi), 64'hFFFF_FFFF);
      check("mult_neg_lo_const", 64'(Lo), 64'hFFFF_FFEB);

      do_op("multu_max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_max_const", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
      do_op("mult_m1", ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mult_m1_const", {Hi, Lo}, 64'h0000_0000_0000_0001);

      do_op("mthi", ALU_MTHI, 32'd5, 32'd0);
      do_op("mtlo", ALU_MTLO, 32'd10, 32'd0);
      do_op("madd", ALU_MADD, 32'd2, 32'd3);
      check("madd_const", {Hi, Lo}, {32'd5, 32'd16});
      do_op("msub", ALU_MSUB, 32'h8000_0000, 32'd2);
      check("msub_const", {Hi, Lo}, {32'd6, 32'd16});

      do_op("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0000);
      check("mul_result_const", 64'(Result), 64'd0);
      check("mul_hilo_const", {Hi, Lo}, {32'd6, 32'd16});
      do_op("mflo", ALU_MFLO, 32'd0, 32'd0);
      check("mflo_result_const", 64'(Result), 64'd16);
      @(negedge Clk);
      check("done_is_pulse", 64'(Done), 64'd0);

      do_op("bad_code", 5'b00000, 32'h1234_5678, 32'd9);

      codes = '{ALU_MULT, ALU_MULTU, ALU_MADD, ALU_MSUB, ALU_MUL, ALU_MTHI,
                ALU_MTLO, ALU_MFHI, ALU_MFLO, 5'b11111, 5'b00001};
      for (int i = 0; i < 60; i++) begin
         do_op($sformatf("rand%0d", i), codes[$urandom_range(0, 10)],
               pick_operand(), pick_operand());
      end

      // Start while busy is dropped; a mid-op reset aborts without Done.
      ALUCtl = ALU_MULT;
      A      = 32'd7;
      B      = 32'd9;
      Start  = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      ALUCtl = ALU_MTHI;
      A      = 32'hDEAD_BEEF;
      Start  = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      check("busy_ignore_hi", 64'(Hi), 64'(m_hi));
      check("busy_ignore_done", 64'(Done), 64'd0);
      check("busy_ignore_busy", 64'(Busy), 64'd1);
      repeat (4) @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      m_res = '0;
      check("abort_busy", 64'(Busy), 64'd0);
      check("abort_hilo", {Hi, Lo}, 64'd0);
      check("abort_result", 64'(Result), 64'd0);
      done_cnt = 0;
      repeat (40) begin
         @(negedge Clk);
         if (Done) done_cnt++;
      end
      check("abort_no_done", 64'(done_cnt), 64'd0);
      do_op("after_abort", ALU_MULTU, 32'd3, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
